cnn_train_sequencer: RTL and testbench
======================================

# cnn_train_sequencer

Top-level training sequencer for the CNN datapath (conv → max-pool → flatten → fully connected → softmax → cross-entropy). It runs a one-time randomized parameter initialization from the LFSR: conv kernels one channel per cycle, then FC weight rows one per cycle. It then accepts training samples through a valid/ready handshake. For each sample it waits a fixed number of settle cycles while the combinational forward/backward paths resolve, then pulses a single weight/kernel commit. It sits beside the datapath in the CNN top level and drives the register enables that were previously hard-wired into the top-level state logic.

## Interface

Parameters:
- CHANNELS, 10, number of conv kernels; CONV_INIT lasts this many cycles
- FCL_INPUT_DIM, 4, FC input count; FCL_INIT lasts FCL_INPUT_DIM+1 cycles (weights plus bias row)
- SETTLE_CYCLES, 4, cycles allowed for the combinational forward+backward path per sample; legal range ≥1
- CNT_WIDTH, 16, width of sample counters

Ports:
- clk, in, 1: clock
- reset, in, 1: asynchronous, active-low
- start, in, 1: begin a training run; honoured only in IDLE
- num_samples, in, CNT_WIDTH: samples per run; latched on accepted start
- sample_valid, in, 1: upstream presents input_data/input_labels
- sample_ready, out, 1: sequencer can accept a sample
- sample_load, out, 1: capture-enable for datapath input registers; equals sample_valid & sample_ready
- init_conv_we, out, 1: write LFSR value into conv kernel slot init_conv_idx
- init_conv_idx, out, $clog2(CHANNELS)+1: kernel index being initialized
- init_fcl_we, out, 1: write LFSR value into FC weight row init_fcl_idx
- init_fcl_idx, out, $clog2(FCL_INPUT_DIM+1)+1: FC row index being initialized
- update_en, out, 1: one-cycle commit of output_weights→input_weights and output_kernels→input_kernels
- busy, out, 1: high in every state except IDLE
- done, out, 1: one-cycle pulse at end of run
- samples_done, out, CNT_WIDTH: samples committed in current/last run

## Operation

- States: IDLE, LFSR_WARM, CONV_INIT, FCL_INIT, WAIT_SAMPLE, SETTLE, UPDATE, DONE.
- IDLE: start=1 → LFSR_WARM; latch num_samples; clear samples_done and index counters.
- LFSR_WARM: 1 cycle, no outputs → CONV_INIT.
- CONV_INIT: init_conv_we=1, init_conv_idx counts 0..CHANNELS-1 one per cycle; after idx CHANNELS-1 → FCL_INIT.
- FCL_INIT: init_fcl_we=1, init_fcl_idx counts 0..FCL_INPUT_DIM one per cycle; after idx FCL_INPUT_DIM → WAIT_SAMPLE, or DONE if latched num_samples==0.
- WAIT_SAMPLE: sample_ready=1; when sample_valid=1, sample_load=1 that cycle → SETTLE with settle counter = SETTLE_CYCLES-1.
- SETTLE: count down; at 0 → UPDATE.
- UPDATE: update_en=1 for one cycle; samples_done increments; if the new value equals num_samples → DONE, else → WAIT_SAMPLE.
- DONE: done=1 for one cycle → IDLE; samples_done holds until the next accepted start.
- Indices are 0 outside their init state. we/ready/update_en/done are 0 outside their named state.
- start outside IDLE is ignored and does not relatch num_samples. num_samples changes after latch have no effect.
- sample_valid outside WAIT_SAMPLE is not consumed. Upstream holds valid and data until the handshake.
- samples_done compare is exact equality; num_samples = 2^CNT_WIDTH-1 is legal.

## Timing

- Reset (any state, including mid-init/SETTLE): immediately IDLE. All outputs 0, samples_done=0, counters 0. No update_en emitted for the interrupted sample.
- Outputs decoded from registered state/counters. sample_load is the only combinational output (valid & ready).
- start sampled at edge E0. Defaults: CONV_INIT during cycles after E1..E10, FCL_INIT after E11..E15, sample_ready high after E16. In general, ready rises CHANNELS+FCL_INPUT_DIM+2 edges after start.
- Handshake at edge H: SETTLE for SETTLE_CYCLES cycles. update_en high in the cycle after edge H+SETTLE_CYCLES. Back in WAIT_SAMPLE (or DONE) after edge H+SETTLE_CYCLES+1.
- Max throughput: one sample per SETTLE_CYCLES+2 cycles.
- done is high in the cycle after the final UPDATE. busy falls the cycle after done.

## Test plan

- Reset asserted, then released with start=0: all outputs 0, state IDLE, busy=0 indefinitely.
- Init sequence: start pulse, num_samples=3 (defaults) → init_conv_we high 10 cycles with idx 0..9, then init_fcl_we high 5 cycles with idx 0..4, sample_ready high 16 edges after start.
- Streaming: 3 samples, sample_valid held high → 3 sample_load pulses 6 cycles apart, 3 update_en pulses 5 cycles after each load, samples_done 1,2,3, then done pulse, busy low next cycle.
- Backpressure: sample_valid low 7 cycles in WAIT_SAMPLE → ready stays high, no load/update; first valid cycle produces sample_load same cycle.
- num_samples=0 → full init, then done directly after FCL_INIT; no sample_ready, no update_en. A second start during this run is ignored.
- Reset driven low in SETTLE of sample 2 → outputs 0 immediately, no update_en. A new start then reruns init from idx 0 with samples_done=0.

Source files
------------

// File: rtl/cnn_train_sequencer_if.sv
// Sample handshake between the upstream sample source and the training sequencer.
// sample_load is the datapath capture-enable, visible to both sides.
interface cnn_train_sequencer_if;
    logic sample_valid;
    logic sample_ready;
    logic sample_load;

    modport master (
        output sample_valid,
        input  sample_ready,
        input  sample_load
    );

    modport slave (
        input  sample_valid,
        output sample_ready,
        output sample_load
    );
endinterface

// File: rtl/cnn_train_sequencer.sv
// Training sequencer: LFSR-driven parameter init, then per-sample accept/settle/commit.
// All outputs except sample_load are registered alongside the state.
module cnn_train_sequencer #(
    parameter int unsigned CHANNELS      = 10,
    parameter int unsigned FCL_INPUT_DIM = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    localparam int unsigned CONV_IDX_W   = $clog2(CHANNELS) + 1,
    localparam int unsigned FCL_IDX_W    = $clog2(FCL_INPUT_DIM + 1) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_WIDTH-1:0]       num_samples,
    cnn_train_sequencer_if.slave       smp,
    output logic                       init_conv_we,
    output logic [CONV_IDX_W-1:0]      init_conv_idx,
    output logic                       init_fcl_we,
    output logic [FCL_IDX_W-1:0]       init_fcl_idx,
    output logic                       update_en,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       samples_done
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLfsrWarm,
        StConvInit,
        StFclInit,
        StWaitSample,
        StSettle,
        StUpdate,
        StDone
    } state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  num_samples_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic                  sample_ready_q;
    logic [CNT_WIDTH-1:0]  samples_done_inc;

    assign samples_done_inc = samples_done + CNT_WIDTH'(1);
    assign smp.sample_ready = sample_ready_q;
    assign smp.sample_load  = smp.sample_valid & sample_ready_q;
    assign busy             = (state_q != StIdle);

    // Each transition also loads the output registers for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            num_samples_q  <= '0;
            settle_cnt_q   <= '0;
            sample_ready_q <= 1'b0;
            init_conv_we   <= 1'b0;
            init_conv_idx  <= '0;
            init_fcl_we    <= 1'b0;
            init_fcl_idx   <= '0;
            update_en      <= 1'b0;
            done           <= 1'b0;
            samples_done   <= '0;
        end else begin
            init_conv_we   <= 1'b0;
            init_fcl_we    <= 1'b0;
            sample_ready_q <= 1'b0;
            update_en      <= 1'b0;
            done           <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StLfsrWarm;
                        num_samples_q <= num_samples;
                        samples_done  <= '0;
                        init_conv_idx <= '0;
                        init_fcl_idx  <= '0;
                    end
                end
                StLfsrWarm: begin
                    state_q       <= StConvInit;
                    init_conv_we  <= 1'b1;
                    init_conv_idx <= '0;
                end
                StConvInit: begin
                    if (init_conv_idx == CONV_IDX_W'(CHANNELS - 1)) begin
                        state_q       <= StFclInit;
                        init_conv_idx <= '0;
                        init_fcl_we   <= 1'b1;
                        init_fcl_idx  <= '0;
                    end else begin
                        init_conv_we  <= 1'b1;
                        init_conv_idx <= init_conv_idx + CONV_IDX_W'(1);
                    end
                end
                StFclInit: begin
                    if (init_fcl_idx == FCL_IDX_W'(FCL_INPUT_DIM)) begin
                        init_fcl_idx <= '0;
                        if (num_samples_q == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q        <= StWaitSample;
                            sample_ready_q <= 1'b1;
                        end
                    end else begin
                        init_fcl_we  <= 1'b1;
                        init_fcl_idx <= init_fcl_idx + FCL_IDX_W'(1);
                    end
                end
                StWaitSample: begin
                    if (smp.sample_valid) begin
                        state_q      <= StSettle;
                        settle_cnt_q <= SETTLE_W'(SETTLE_CYCLES - 1);
                    end else begin
                        sample_ready_q <= 1'b1;
                    end
                end
                StSettle: begin
                    if (settle_cnt_q == '0) begin
                        state_q   <= StUpdate;
                        update_en <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                    end
                end
                StUpdate: begin
                    samples_done <= samples_done_inc;
                    if (samples_done_inc == num_samples_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q        <= StWaitSample;
                        sample_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Directed bench for cnn_train_sequencer: init sequence, streaming, backpressure,
// zero-sample run and asynchronous reset during SETTLE.
module tb_cnn_train_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_samples;
    logic        init_conv_we;
    logic [4:0]  init_conv_idx;
    logic        init_fcl_we;
    logic [3:0]  init_fcl_idx;
    logic        update_en;
    logic        busy;
    logic        done;
    logic [15:0] samples_done;

    int n_checks;
    int n_fail;

    cnn_train_sequencer_if smp ();

    cnn_train_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_samples   (num_samples),
        .smp           (smp),
        .init_conv_we  (init_conv_we),
        .init_conv_idx (init_conv_idx),
        .init_fcl_we   (init_fcl_we),
        .init_fcl_idx  (init_fcl_idx),
        .update_en     (update_en),
        .busy          (busy),
        .done          (done),
        .samples_done  (samples_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed strobes: {conv_we, fcl_we, ready, load, update_en, done}
    function automatic logic [31:0] strobes();
        return {26'd0, init_conv_we, init_fcl_we, smp.sample_ready, smp.sample_load,
                update_en, done};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start with n samples and check the whole init sequence; leaves the bench
    // at the negedge where WAIT_SAMPLE (or DONE) is first visible.
    task automatic run_init(input logic [15:0] n, input bit stray_start);
        start       = 1'b1;
        num_samples = n;
        tick();
        start       = 1'b0;
        num_samples = 16'd7;
        check("warm_busy", {31'd0, busy}, 32'd1);
        check("warm_strobes", strobes(), 32'd0);
        check("warm_samples_done", {16'd0, samples_done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("conv_strobes", strobes(), 32'h20);
            check("conv_idx", {27'd0, init_conv_idx}, i);
            if (stray_start && i == 3) start = 1'b1;
            if (stray_start && i == 4) start = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fcl_strobes", strobes(), 32'h10);
            check("fcl_idx", {28'd0, init_fcl_idx}, i);
            check("fcl_conv_idx_zero", {27'd0, init_conv_idx}, 32'd0);
        end
        tick();
        check("post_init_fcl_idx", {28'd0, init_fcl_idx}, 32'd0);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b0;
        start            = 1'b0;
        num_samples      = 16'd0;
        smp.sample_valid = 1'b0;

        // Reset and idle
        tick();
        tick();
        check("rst_strobes", strobes(), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_strobes", strobes(), 32'd0);
            check("idle_samples_done", {16'd0, samples_done}, 32'd0);
        end

        // Run 1: three samples with valid held high
        run_init(16'd3, 1'b0);
        smp.sample_valid = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            #1;
            check("stream_ready_load", strobes(), 32'h0c);
            for (int k = 0; k < 4; k++) begin
                tick();
                check("stream_settle", strobes(), 32'd0);
                check("stream_settle_busy", {31'd0, busy}, 32'd1);
            end
            tick();
            check("stream_update", strobes(), 32'h02);
            check("stream_cnt_before", {16'd0, samples_done}, s - 1);
            tick();
            check("stream_samples_done", {16'd0, samples_done}, s);
        end
        smp.sample_valid = 1'b0;
        check("stream_done", strobes(), 32'h01);
        tick();
        check("stream_busy_low", {31'd0, busy}, 32'd0);
        check("stream_after_done", strobes(), 32'd0);
        check("stream_hold_cnt", {16'd0, samples_done}, 32'd3);

        // Run 2: backpressure on sample 1, reset during SETTLE of sample 2
        tick();
        run_init(16'd3, 1'b0);
        check("bp_cnt_cleared", {16'd0, samples_done}, 32'd0);
        for (int k = 0; k < 7; k++) begin
            check("bp_wait", strobes(), 32'h08);
            tick();
        end
        check("bp_wait_last", strobes(), 32'h08);
        smp.sample_valid = 1'b1;
        #1;
        check("bp_load", strobes(), 32'h0c);
        tick();
        smp.sample_valid = 1'b0;
        repeat (4) tick();
        check("bp_update", strobes(), 32'h02);
        tick();
        check("bp_cnt1", {16'd0, samples_done}, 32'd1);
        check("bp_ready2", strobes(), 32'h08);
        smp.sample_valid = 1'b1;
        tick();
        smp.sample_valid = 1'b0;
        tick();
        check("rst_mid_settle_pre", strobes(), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cnt", {16'd0, samples_done}, 32'd0);
        check("rst_mid_strobes", strobes(), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_hold_strobes", strobes(), 32'd0);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rst_after_strobes", strobes(), 32'd0);
            check("rst_after_busy", {31'd0, busy}, 32'd0);
        end

        // Run 3: zero samples, stray start during init must be ignored
        run_init(16'd0, 1'b1);
        check("zero_done", strobes(), 32'h01);
        check("zero_cnt", {16'd0, samples_done}, 32'd0);
        tick();
        check("zero_busy_low", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("zero_idle_strobes", strobes(), 32'd0);
            check("zero_idle_busy", {31'd0, busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
